// File: rtl/fifo_pair_write_arbiter.sv
// fifo_pair_write_arbiter
// Write-side scheduler for a FIFO that takes two words per write. Up to
// NUM_REQ single-word producers are arbitrated round-robin (at most two
// grants per cycle). Accepted words are packed into pairs, and one pair
// write is issued per cycle. A lone word waiting for its partner is padded
// out with PAD_WORD on Flush_in, or after FLUSH_TIMEOUT idle cycles.
//
// Optional build macro: PAIR_STATS_EN adds live Pair_count/Pad_count
// counters. Without it, both ports read as zero.
//
// Ports:
//   WClk          clock
//   Clear_in      synchronous active-high reset
//   Req_valid     per-requester word valid
//   Req_data      requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   Req_ready     per-requester grant (combinational)
//   Flush_in      force out a held half-pair
//   Full_in       FIFO full; blocks all grants and writes
//   Data_out_1    older word of the pair
//   Data_out_2    newer word of the pair, or PAD_WORD
//   WriteEn_out_2 pair write strobe (registered)
//   Half_held     one word is waiting for its partner
//   Pair_count    number of pair writes issued (PAIR_STATS_EN)
//   Pad_count     number of padded writes issued (PAIR_STATS_EN)
module fifo_pair_write_arbiter #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    NUM_REQ       = 4,
  parameter int                    FLUSH_TIMEOUT = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD      = {DATA_WIDTH{1'b1}}
) (
  input  logic                          WClk,
  input  logic                          Clear_in,
  input  logic [NUM_REQ-1:0]            Req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_data,
  output logic [NUM_REQ-1:0]            Req_ready,
  input  logic                          Flush_in,
  input  logic                          Full_in,
  output logic [DATA_WIDTH-1:0]         Data_out_1,
  output logic [DATA_WIDTH-1:0]         Data_out_2,
  output logic                          WriteEn_out_2,
  output logic                          Half_held,
  output logic [31:0]                   Pair_count,
  output logic [15:0]                   Pad_count
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                  state_r, state_s;
  logic [PTR_W-1:0]        rr_ptr_r, rr_ptr_s;
  logic [TMR_W-1:0]        timer_r, timer_s;
  logic [DATA_WIDTH-1:0]   half_r, half_s;
  logic [DATA_WIDTH-1:0]   d1_r, d1_s, d2_r, d2_s;
  logic                    wr_en_r, wr_en_s;
  logic [NUM_REQ-1:0]      grant_s;
  logic [PTR_W-1:0]        g0_s, g1_s, idx_s, last_s;
  logic [1:0]              k_s, acc_k_s;
  logic [DATA_WIDTH-1:0]   w0_s, w1_s;
  logic                    blocked_s, timer_hit_s;

  // Round-robin scan from rr_ptr: first two valid requesters are granted
  always_comb begin
    grant_s = '0;
    g0_s    = '0;
    g1_s    = '0;
    idx_s   = '0;
    k_s     = 2'd0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx_s = PTR_W'((int'(rr_ptr_r) + off) % NUM_REQ);
      if (Req_valid[idx_s] && (k_s != 2'd2)) begin
        if (k_s == 2'd0) begin
          g0_s = idx_s;
        end else begin
          g1_s = idx_s;
        end
        grant_s[idx_s] = 1'b1;
        k_s            = k_s + 2'd1;
      end else begin
        k_s = k_s;
      end
    end
  end

  // Backpressure and reset suppress every grant, so nothing is accepted
  assign blocked_s = Full_in | Clear_in;
  assign Req_ready = blocked_s ? '0 : grant_s;
  assign acc_k_s   = blocked_s ? 2'd0 : k_s;
  assign w0_s      = Req_data[g0_s*DATA_WIDTH +: DATA_WIDTH];
  assign w1_s      = Req_data[g1_s*DATA_WIDTH +: DATA_WIDTH];
  assign last_s    = (k_s == 2'd2) ? g1_s : g0_s;
  assign timer_hit_s = (FLUSH_TIMEOUT != 0) &&
                       (timer_r == TMR_W'(FLUSH_TIMEOUT - 1));

  // Pairing state machine: next state, next write, timer and pointer
  always_comb begin
    state_s  = state_r;
    half_s   = half_r;
    d1_s     = d1_r;
    d2_s     = d2_r;
    wr_en_s  = 1'b0;
    timer_s  = timer_r;
    rr_ptr_s = rr_ptr_r;
    if (acc_k_s != 2'd0) begin
      rr_ptr_s = PTR_W'((int'(last_s) + 1) % NUM_REQ);
    end else begin
      rr_ptr_s = rr_ptr_r;
    end
    // Everything, including pending flush/timeout pads, waits while full
    if (!Full_in) begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_k_s == 2'd2) begin
            wr_en_s = 1'b1;
            d1_s    = w0_s;
            d2_s    = w1_s;
            timer_s = '0;
          end else if (acc_k_s == 2'd1) begin
            half_s  = w0_s;
            state_s = ST_HOLD;
            timer_s = '0;
          end else begin
            timer_s = timer_r;
          end
        end
        ST_HOLD: begin
          if (acc_k_s != 2'd0) begin
            // Real pairing wins over a simultaneous flush
            wr_en_s = 1'b1;
            d1_s    = half_r;
            d2_s    = w0_s;
            timer_s = '0;
            if (acc_k_s == 2'd2) begin
              half_s = w1_s;
            end else begin
              state_s = ST_EMPTY;
            end
          end else if (Flush_in || timer_hit_s) begin
            wr_en_s = 1'b1;
            d1_s    = half_r;
            d2_s    = PAD_WORD;
            state_s = ST_EMPTY;
            timer_s = '0;
          end else if (FLUSH_TIMEOUT != 0) begin
            timer_s = timer_r + TMR_W'(1);
          end else begin
            timer_s = timer_r;
          end
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end else begin
      timer_s = timer_r;
    end
  end

  // State and registered FIFO write port
  always_ff @(posedge WClk) begin
    if (Clear_in) begin
      state_r  <= ST_EMPTY;
      rr_ptr_r <= '0;
      timer_r  <= '0;
      half_r   <= '0;
      d1_r     <= '0;
      d2_r     <= '0;
      wr_en_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      rr_ptr_r <= rr_ptr_s;
      timer_r  <= timer_s;
      half_r   <= half_s;
      d1_r     <= d1_s;
      d2_r     <= d2_s;
      wr_en_r  <= wr_en_s;
    end
  end

  assign Data_out_1    = d1_r;
  assign Data_out_2    = d2_r;
  assign WriteEn_out_2 = wr_en_r;
  assign Half_held     = (state_r == ST_HOLD);

`ifdef PAIR_STATS_EN
  logic [31:0] pair_cnt_r;
  logic [15:0] pad_cnt_r;
  logic        pad_s;

  // A pad write is the only write issued from HOLD with nothing accepted
  assign pad_s = wr_en_s && (state_r == ST_HOLD) && (acc_k_s == 2'd0);

  // Counters advance on the same edge that raises the write strobe
  always_ff @(posedge WClk) begin
    if (Clear_in) begin
      pair_cnt_r <= 32'd0;
      pad_cnt_r  <= 16'd0;
    end else if (wr_en_s) begin
      pair_cnt_r <= pair_cnt_r + 32'd1;
      pad_cnt_r  <= pad_s ? (pad_cnt_r + 16'd1) : pad_cnt_r;
    end else begin
      pair_cnt_r <= pair_cnt_r;
      pad_cnt_r  <= pad_cnt_r;
    end
  end

  assign Pair_count = pair_cnt_r;
  assign Pad_count  = pad_cnt_r;
`else
  assign Pair_count = 32'd0;
  assign Pad_count  = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_pair_write_arbiter.sv
// Directed bench for fifo_pair_write_arbiter (default parameters:
// 8-bit words, 4 requesters, timeout 16, pad 8'hFF).
module tb_fifo_pair_write_arbiter;

  logic        clk;
  logic        clear;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  req_ready;
  logic        flush;
  logic        full;
  logic [7:0]  dout1;
  logic [7:0]  dout2;
  logic        wr_en;
  logic        half_held;
  logic [31:0] pair_count;
  logic [15:0] pad_count;

  int checks = 0;
  int errors = 0;

  fifo_pair_write_arbiter dut (
    .WClk          (clk),
    .Clear_in      (clear),
    .Req_valid     (valid),
    .Req_data      (data),
    .Req_ready     (req_ready),
    .Flush_in      (flush),
    .Full_in       (full),
    .Data_out_1    (dout1),
    .Data_out_2    (dout2),
    .WriteEn_out_2 (wr_en),
    .Half_held     (half_held),
    .Pair_count    (pair_count),
    .Pad_count     (pad_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        clr;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        flush;
    logic        full;
    logic [3:0]  exp_ready;
    logic        exp_wr;
    logic [7:0]  exp_d1;
    logic [7:0]  exp_d2;
    logic        exp_half;
  } vec_t;

  vec_t vec [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle: inputs at negedge, sample ready #1 later, return #1 after posedge
  task automatic cycle(input logic clr, input logic [3:0] v, input logic [31:0] d,
                       input logic fl, input logic fu, output logic [3:0] rdy);
    @(negedge clk);
    clear = clr;
    valid = v;
    data  = d;
    flush = fl;
    full  = fu;
    #1 rdy = req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string name, input int pairs, input int pads);
`ifdef PAIR_STATS_EN
    chk({name, "_pair_count"}, pair_count, 32'(pairs));
    chk({name, "_pad_count"}, {16'd0, pad_count}, 32'(pads));
`else
    chk({name, "_pair_count"}, pair_count, 32'd0);
    chk({name, "_pad_count"}, {16'd0, pad_count}, 32'd0);
`endif
  endtask

  logic [3:0] rdy;
  logic [3:0] exp_rdy;
  logic [7:0] n [4];
  int         j;
  logic       fu;
  logic [1:0] lo;

  initial begin
    clear = 1'b1; valid = 4'h0; data = 32'h0; flush = 1'b0; full = 1'b0;

    //           clr   valid  data          flush full  ready wr    d1     d2     half
    vec[0]  = '{1'b1, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0};
    vec[1]  = '{1'b1, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0};
    vec[2]  = '{1'b1, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0};
    vec[3]  = '{1'b1, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0};
    vec[4]  = '{1'b0, 4'h3, 32'h00000201, 1'b0, 1'b0, 4'h3, 1'b1, 8'h01, 8'h02, 1'b0};
    vec[5]  = '{1'b0, 4'hF, 32'h13121110, 1'b0, 1'b0, 4'hC, 1'b1, 8'h12, 8'h13, 1'b0};
    vec[6]  = '{1'b0, 4'h1, 32'h00000003, 1'b0, 1'b0, 4'h1, 1'b0, 8'h12, 8'h13, 1'b1};
    vec[7]  = '{1'b0, 4'h1, 32'h00000005, 1'b0, 1'b0, 4'h1, 1'b1, 8'h03, 8'h05, 1'b0};
    vec[8]  = '{1'b0, 4'h1, 32'h00000007, 1'b0, 1'b0, 4'h1, 1'b0, 8'h03, 8'h05, 1'b1};
    vec[9]  = '{1'b0, 4'h0, 32'h00000000, 1'b1, 1'b0, 4'h0, 1'b1, 8'h07, 8'hFF, 1'b0};
    vec[10] = '{1'b0, 4'h0, 32'h00000000, 1'b1, 1'b0, 4'h0, 1'b0, 8'h07, 8'hFF, 1'b0};
    vec[11] = '{1'b0, 4'h4, 32'h00210000, 1'b0, 1'b0, 4'h4, 1'b0, 8'h07, 8'hFF, 1'b1};
    vec[12] = '{1'b0, 4'h9, 32'h33000030, 1'b1, 1'b0, 4'h9, 1'b1, 8'h21, 8'h33, 1'b1};
    vec[13] = '{1'b0, 4'hF, 32'h00000000, 1'b1, 1'b1, 4'h0, 1'b0, 8'h21, 8'h33, 1'b1};
    vec[14] = '{1'b0, 4'h0, 32'h00000000, 1'b1, 1'b0, 4'h0, 1'b1, 8'h30, 8'hFF, 1'b0};
    vec[15] = '{1'b0, 4'hE, 32'h43424100, 1'b0, 1'b0, 4'h6, 1'b1, 8'h41, 8'h42, 1'b0};
    vec[16] = '{1'b0, 4'hA, 32'h53005100, 1'b0, 1'b0, 4'hA, 1'b1, 8'h53, 8'h51, 1'b0};
    vec[17] = '{1'b0, 4'h2, 32'h00006100, 1'b0, 1'b0, 4'h2, 1'b0, 8'h53, 8'h51, 1'b1};
    vec[18] = '{1'b1, 4'hF, 32'h00000000, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0};
    vec[19] = '{1'b0, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b0};

    for (int i = 0; i < 20; i++) begin
      cycle(vec[i].clr, vec[i].valid, vec[i].data, vec[i].flush, vec[i].full, rdy);
      chk($sformatf("vec%0d_ready", i), {28'd0, rdy}, {28'd0, vec[i].exp_ready});
      chk($sformatf("vec%0d_wr", i), {31'd0, wr_en}, {31'd0, vec[i].exp_wr});
      chk($sformatf("vec%0d_d1", i), {24'd0, dout1}, {24'd0, vec[i].exp_d1});
      chk($sformatf("vec%0d_d2", i), {24'd0, dout2}, {24'd0, vec[i].exp_d2});
      chk($sformatf("vec%0d_half", i), {31'd0, half_held}, {31'd0, vec[i].exp_half});
    end

    // Timeout: word 7 held, pad goes out after exactly 16 idle cycles
    cycle(1'b0, 4'h1, 32'h00000007, 1'b0, 1'b0, rdy);
    chk("to_accept_ready", {28'd0, rdy}, 32'h1);
    chk("to_accept_half", {31'd0, half_held}, 32'd1);
    for (int i = 1; i <= 15; i++) begin
      cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rdy);
      chk($sformatf("to_idle%0d_wr", i), {31'd0, wr_en}, 32'd0);
      chk($sformatf("to_idle%0d_half", i), {31'd0, half_held}, 32'd1);
    end
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rdy);
    chk("to_pad_wr", {31'd0, wr_en}, 32'd1);
    chk("to_pad_d1", {24'd0, dout1}, 32'h07);
    chk("to_pad_d2", {24'd0, dout2}, 32'hFF);
    chk("to_pad_half", {31'd0, half_held}, 32'd0);

    // Backpressure: 5 idle, 10 full (timer frozen), pad after 11 more idle
    cycle(1'b0, 4'h1, 32'h0000005A, 1'b0, 1'b0, rdy);
    chk("bp_accept_ready", {28'd0, rdy}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rdy);
      chk($sformatf("bp_pre%0d_wr", i), {31'd0, wr_en}, 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 4'hF, 32'h0, 1'b0, 1'b1, rdy);
      chk($sformatf("bp_full%0d_ready", i), {28'd0, rdy}, 32'h0);
      chk($sformatf("bp_full%0d_wr", i), {31'd0, wr_en}, 32'd0);
      chk($sformatf("bp_full%0d_half", i), {31'd0, half_held}, 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rdy);
      chk($sformatf("bp_post%0d_wr", i), {31'd0, wr_en}, 32'd0);
    end
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rdy);
    chk("bp_pad_wr", {31'd0, wr_en}, 32'd1);
    chk("bp_pad_d1", {24'd0, dout1}, 32'h5A);
    chk("bp_pad_d2", {24'd0, dout2}, 32'hFF);
    chk("bp_pad_half", {31'd0, half_held}, 32'd0);
    chk_stats("mid", 2, 2);

    // Fairness: all four valid; lane i sends i*64+n; short full burst mid-stream
    cycle(1'b1, 4'hF, 32'h0, 1'b0, 1'b0, rdy);
    chk("fair_clear_ready", {28'd0, rdy}, 32'h0);
    for (int i = 0; i < 4; i++) n[i] = 8'd0;
    j = 0;
    for (int c = 0; c < 23; c++) begin
      fu = (c >= 8 && c <= 10);
      cycle(1'b0, 4'hF, {8'd192 + n[3], 8'd128 + n[2], 8'd64 + n[1], n[0]}, 1'b0, fu, rdy);
      lo      = (j % 2 == 0) ? 2'd0 : 2'd2;
      exp_rdy = fu ? 4'h0 : ((lo == 2'd0) ? 4'h3 : 4'hC);
      chk($sformatf("fair%0d_ready", c), {28'd0, rdy}, {28'd0, exp_rdy});
      chk($sformatf("fair%0d_wr", c), {31'd0, wr_en}, {31'd0, !fu});
      if (!fu) begin
        chk($sformatf("fair%0d_d1", c), {24'd0, dout1}, {24'd0, 8'(64 * lo) + n[lo]});
        chk($sformatf("fair%0d_d2", c), {24'd0, dout2}, {24'd0, 8'(64 * (lo + 2'd1)) + n[lo + 2'd1]});
        n[lo]         = n[lo] + 8'd1;
        n[lo + 2'd1]  = n[lo + 2'd1] + 8'd1;
        j++;
      end else begin
        chk($sformatf("fair%0d_hold_d1", c), {24'd0, dout1}, {24'd0, 8'(64 * (2 - lo)) + n[2 - lo] - 8'd1});
      end
    end
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, rdy);
    chk("fair_end_wr", {31'd0, wr_en}, 32'd0);
    chk("fair_end_half", {31'd0, half_held}, 32'd0);
    chk_stats("end", 20, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
